// File: rtl/datapath_pkg.sv
// Shared datapath geometry and types for the writeback/register-file slice.
package datapath_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] regaddr_t;

  // Architectural zero register: reads as 0, writes are discarded.
  localparam regaddr_t REG_ZERO = '0;

endpackage

// File: rtl/s4_writeback_regfile_read_port.sv
// One register-file read port: r0 forcing plus optional same-cycle write-through.
// Bypass behaviour is selected by the WB_BYPASS_EN macro.
module wb_read_port
  import datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_live,
  input  logic [ADDR_W-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data
);

  logic is_zero;
  logic hit;

  assign is_zero = (rd_addr == ADDR_W'(REG_ZERO));
  assign hit     = wr_live && (wb_sel == rd_addr) && !is_zero;

`ifdef WB_BYPASS_EN
  always_comb begin
    rd_data = stored;
    if (is_zero) rd_data = '0;
    else if (hit) rd_data = wb_data;
  end
`else
  // Without bypass the write becomes visible from the next cycle only.
  logic unused_bypass;
  assign unused_bypass = hit ^ (^wb_data);

  always_comb begin
    rd_data = stored;
    if (is_zero) rd_data = '0;
  end
`endif

endmodule

// File: rtl/s4_writeback_regfile.sv
// Stage-4 writeback register file: one write port, two combinational read ports.
// Define WB_BYPASS_EN to forward same-cycle writes to matching reads.
module s4_writeback_regfile
  import datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_sel,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [31:0]       wr_count,
  output logic              r0_drop
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_p1 [NREGS];
  logic [31:0]       wr_count_p1;
  logic              r0_drop_p1;

  logic sel_zero;
  logic commit;
  logic wr_live;

  assign sel_zero = (wb_sel == ADDR_W'(REG_ZERO));
  assign commit   = wb_en && !sel_zero;
  // Reads during reset come from the array only; the lost write is never forwarded.
  assign wr_live  = wb_en && !rst;

  // ---- stage 4 commit: write latency one cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_p1[i] <= '0;
      wr_count_p1 <= '0;
      r0_drop_p1  <= 1'b0;
    end else begin
      r0_drop_p1 <= wb_en && sel_zero;
      if (commit) begin
        regs_p1[wb_sel] <= wb_data;
        wr_count_p1     <= wr_count_p1 + 32'd1;
      end
    end
  end

  assign wr_count = wr_count_p1;
  assign r0_drop  = r0_drop_p1;

  wb_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .rd_addr (rd_addr_a),
    .stored  (regs_p1[rd_addr_a]),
    .wr_live (wr_live),
    .wb_sel  (wb_sel),
    .wb_data (wb_data),
    .rd_data (rd_data_a)
  );

  wb_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .rd_addr (rd_addr_b),
    .stored  (regs_p1[rd_addr_b]),
    .wr_live (wr_live),
    .wb_sel  (wb_sel),
    .wb_data (wb_data),
    .rd_data (rd_data_b)
  );

endmodule

// File: tb/tb_s4_writeback_regfile.sv
// Scoreboard bench for s4_writeback_regfile; expectations follow WB_BYPASS_EN.
module tb_s4_writeback_regfile;
  import datapath_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  word_t    wb_data = '0;
  regaddr_t wb_sel = '0;
  logic     wb_en = 1'b0;
  regaddr_t rd_addr_a = '0;
  regaddr_t rd_addr_b = '0;
  word_t    rd_data_a;
  word_t    rd_data_b;
  logic [31:0] wr_count;
  logic     r0_drop;

  s4_writeback_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb_data   (wb_data),
    .wb_sel    (wb_sel),
    .wb_en     (wb_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_count  (wr_count),
    .r0_drop   (r0_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    regaddr_t    sel;
    word_t       data;
    regaddr_t    ra;
    regaddr_t    rb;
    bit          preload;
    bit          chk;
    word_t       exp_a;
    word_t       exp_b;
    logic [31:0] exp_cnt;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   drv_done = 1'b0;

  function automatic vec_t mk(string name, logic r, logic en, regaddr_t sel, word_t data,
                              regaddr_t ra, regaddr_t rb, bit chk, word_t ea, word_t eb,
                              logic [31:0] ec, logic ed);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.sel = sel; v.data = data;
    v.ra = ra; v.rb = rb; v.preload = 1'b0; v.chk = chk;
    v.exp_a = ea; v.exp_b = eb; v.exp_cnt = ec; v.exp_drop = ed;
    return v;
  endfunction

  // Each expectation describes the outputs seen during that vector's cycle,
  // i.e. state from earlier edges plus this cycle's combinational reads.
  initial begin
    vec_t v;
    vecs.push_back(mk("reset", 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    for (int i = 1; i < 32; i++)
      vecs.push_back(mk("post_reset_read", 0, 0, 0, 0, regaddr_t'(i),
                        regaddr_t'((i % 31) + 1), 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr_r5", 0, 1, 5, 32'hDEADBEEF, 5, 0, 1,
                      BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0));
    vecs.push_back(mk("rd_r5", 0, 0, 0, 0, 5, 5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk("wr_r0", 0, 1, 0, 32'h12345678, 0, 5, 1, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk("r0_drop_hi", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("r0_drop_lo", 0, 0, 0, 0, 5, 0, 1, 32'hDEADBEEF, 0, 1, 0));
    vecs.push_back(mk("wr_r7_1", 0, 1, 7, 32'h1, 7, 7, 1,
                      BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 1, 0));
    vecs.push_back(mk("wr_r7_2_rd", 0, 1, 7, 32'h2, 7, 5, 1,
                      BYP ? 32'h2 : 32'h1, 32'hDEADBEEF, 2, 0));
    vecs.push_back(mk("rd_r7_next", 0, 0, 0, 0, 7, 7, 1, 32'h2, 32'h2, 3, 0));
    vecs.push_back(mk("en0_ignored", 0, 0, 7, 32'hFFFFFFFF, 7, 7, 1, 32'h2, 32'h2, 3, 0));
    vecs.push_back(mk("en0_after", 0, 0, 0, 0, 7, 7, 1, 32'h2, 32'h2, 3, 0));
    v = mk("wrap_wr", 0, 1, 3, 32'h33, 3, 3, 1,
           BYP ? 32'h33 : 32'h0, BYP ? 32'h33 : 32'h0, 32'hFFFFFFFF, 0);
    v.preload = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mk("wrap_cnt", 0, 0, 0, 0, 3, 1, 1, 32'h33, 0, 0, 0));
    vecs.push_back(mk("rst_vs_wr", 1, 1, 9, 32'hAA, 9, 5, 1, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("after_rst", 0, 0, 0, 0, 9, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk("wr_r31", 0, 1, 31, 32'hCAFE0001, 31, 0, 1,
                      BYP ? 32'hCAFE0001 : 32'h0, 0, 0, 0));
    vecs.push_back(mk("rd_r31", 0, 0, 0, 0, 31, 31, 1, 32'hCAFE0001, 32'hCAFE0001, 1, 0));
  end

  // Driver: applies one vector per cycle shortly after the rising edge.
  initial begin
    #1;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      if (vecs[i].preload) begin
        force dut.wr_count_p1 = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_p1;
      end
      rst = vecs[i].rst; wb_en = vecs[i].en; wb_sel = vecs[i].sel;
      wb_data = vecs[i].data; rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      sb.push_back(vecs[i]);
    end
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    drv_done = 1'b1;
  end

  // Monitor: samples on the falling edge and retires one expectation per cycle.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          n_vec++;
          if (rd_data_a !== e.exp_a) begin
            n_miss++;
            $display("FAIL %s rd_data_a got %h want %h", e.name, rd_data_a, e.exp_a);
          end
          if (rd_data_b !== e.exp_b) begin
            n_miss++;
            $display("FAIL %s rd_data_b got %h want %h", e.name, rd_data_b, e.exp_b);
          end
          if (wr_count !== e.exp_cnt) begin
            n_miss++;
            $display("FAIL %s wr_count got %h want %h", e.name, wr_count, e.exp_cnt);
          end
          if (r0_drop !== e.exp_drop) begin
            n_miss++;
            $display("FAIL %s r0_drop got %b want %b", e.name, r0_drop, e.exp_drop);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(drv_done && sb.size() == 0) && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      n_miss++;
      $display("FAIL timeout pending %0d want 0", sb.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/s4_writeback_regfile.md
S4_WRITEBACK_REGFILE -- requirements
Module: s4_writeback_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register select width, giving 2**ADDR_W registers.
REQ-003 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port wb_data  input  DATA_W  result from the stage-3 pipeline register.
REQ-007 SHALL have port wb_sel  input  ADDR_W  destination register from stage 3.
REQ-008 SHALL have port wb_en  input  1  write enable from stage 3.
REQ-009 SHALL have port rd_addr_a  input  ADDR_W  read port A select.
REQ-010 SHALL have port rd_addr_b  input  ADDR_W  read port B select.
REQ-011 SHALL have port rd_data_a  output  DATA_W  read port A data, combinational.
REQ-012 SHALL have port rd_data_b  output  DATA_W  read port B data, combinational.
REQ-013 SHALL have port wr_count  output  32  registered count of committed writes.
REQ-014 SHALL have port r0_drop  output  1  registered one-cycle pulse when a write to r0 is discarded.

Function
REQ-015 SHALL commit wb_data into register wb_sel on the clk edge where wb_en=1, rst=0 and wb_sel!=0; write latency is 1 cycle.
REQ-016 SHALL hold register 0 at constant zero; rd_data_x SHALL be 0 whenever rd_addr_x=0, regardless of any pending write.
REQ-017 SHALL discard a write with wb_en=1 and wb_sel=0, leave wr_count unchanged, and assert r0_drop for the following cycle only.
REQ-018 SHALL increment wr_count by 1 for each committed write, wrapping from 0xFFFFFFFF to 0 with no flag.
REQ-019 SHALL ignore wb_data and wb_sel whenever wb_en=0; registers, wr_count and r0_drop (driven to 0) are then unaffected.
REQ-020 SHALL serve both read ports independently; equal addresses on A and B SHALL return identical data.
REQ-021 SHALL return the stored register value on reads that do not match a same-cycle write (wb_en=1, wb_sel=rd_addr, rd_addr!=0).
REQ-022 SHALL, on a read matching a same-cycle write, return the value defined by the configuration in REQ-026 and REQ-027.

Reset
REQ-023 SHALL, on any clk edge with rst=1, clear all registers to 0, wr_count to 0 and r0_drop to 0.
REQ-024 SHALL give rst priority over a simultaneous write; that write is lost and is not counted.
REQ-025 SHALL, during reset, present rd_data_a and rd_data_b from the current array contents, which read 0 from the cycle after the first reset edge.

Configuration
REQ-026 SHALL, with WB_BYPASS_EN defined, return wb_data combinationally on any read that matches a same-cycle write (write-through bypass).
REQ-027 SHALL, with WB_BYPASS_EN undefined, return the old stored value on such a read; the new value is visible from the next cycle.

Structure
REQ-028 SHALL take DATA_W/ADDR_W defaults, a REG_ZERO address constant, and the regaddr_t and word_t typedefs from shared package datapath_pkg.
REQ-029 SHALL place per-port read selection, including the r0 forcing and bypass compare, in one sub-module wb_read_port, instantiated twice.

Verification
REQ-030 SHALL cover: rst=1 one edge, then read r1..r31 -> all read 0, wr_count=0, r0_drop=0.
REQ-031 SHALL cover: write 0xDEADBEEF to r5, next cycle read A=r5 and B=r5 -> both return 0xDEADBEEF, wr_count=1.
REQ-032 SHALL cover: wb_en=1, wb_sel=0, wb_data=0x12345678 -> r0 reads 0, r0_drop=1 for exactly one cycle, wr_count unchanged.
REQ-033 SHALL cover: r7=0x1 stored, same-cycle write 0x2 to r7 while reading r7 -> reads 0x2 with WB_BYPASS_EN and 0x1 without it; both read 0x2 next cycle.
REQ-034 SHALL cover: preload wr_count to 0xFFFFFFFF via writes (or force), then commit one write -> wr_count=0.
REQ-035 SHALL cover: rst=1 with wb_en=1, wb_sel=9, wb_data=0xAA -> r9 reads 0 and wr_count=0 after the edge.
